// File: rtl/peg_l2_rs_pkg.sv
// Shared definitions for the RMII reconciliation-sublayer TX/RX blocks.
package peg_l2_rs_pkg;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;

   localparam int CYC_PER_BYTE_100 = 4;
   localparam int CYC_PER_BYTE_10  = 40;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_DRAIN,
      ST_IPG
   } tx_state_e;

endpackage

// File: rtl/peg_l2_rs_rr_arb.sv
// Two-requester round-robin arbiter; the requester not granted last wins a tie.
module peg_l2_rs_rr_arb (
   input  logic       rmii_ref_clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic [1:0] grant
);

   // 0 = requester 0 was granted last, 1 = requester 1
   logic last;

   always_comb begin
      grant = 2'b00;
      if (grant_en) begin
         if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
         else              grant = req;
      end
   end

   always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
      if (!rst_n)                          last <= 1'b0;
      else if (grant_en && grant != 2'b00) last <= grant[1];
   end

endmodule

// File: rtl/peg_l2_rs_rmii_tx_sched.sv
// Two-source RMII TX scheduler: packet-boundary arbitration, preamble/SFD
// insertion, byte pass-through, inter-packet gap and source error detection.
module peg_l2_rs_rmii_tx_sched
   import peg_l2_rs_pkg::*;
#(
   parameter int PKT_DATA_W   = 8,
   parameter int NUM_PREAMBLE = 7,
   parameter int IPG_BYTES    = 12
) (
   input  logic                  rmii_ref_clk,
   input  logic                  rst_n,
   input  logic                  config_rs_mii_speed_100_n_10,
   input  logic                  s0_valid,
   input  logic                  s0_sop,
   input  logic                  s0_eop,
   input  logic                  s0_error,
   input  logic [PKT_DATA_W-1:0] s0_data,
   output logic                  s0_ready,
   input  logic                  s1_valid,
   input  logic                  s1_sop,
   input  logic                  s1_eop,
   input  logic                  s1_error,
   input  logic [PKT_DATA_W-1:0] s1_data,
   output logic                  s1_ready,
   output logic                  pkt_valid,
   output logic                  pkt_sop,
   output logic                  pkt_eop,
   output logic                  pkt_error,
   output logic [PKT_DATA_W-1:0] pkt_data,
   input  logic                  pkt_ready,
   output logic [1:0]            stat_grant,
   output logic                  stat_pkt_done,
   output logic                  stat_underrun,
   output logic                  stat_sop_err
);

   localparam logic [2:0] PRE_LAST     = 3'(NUM_PREAMBLE);
   localparam logic [8:0] IPG_LOAD_100 = 9'(IPG_BYTES * CYC_PER_BYTE_100 - 1);
   localparam logic [8:0] IPG_LOAD_10  = 9'(IPG_BYTES * CYC_PER_BYTE_10 - 1);

   tx_state_e             state;
   logic [1:0]            owner;
   logic [2:0]            pre_cnt;
   logic [8:0]            ipg_cnt;
   logic [8:0]            ipg_load;
   logic                  in_idle;
   logic [1:0]            req;
   logic [1:0]            discard;
   logic [1:0]            arb_grant;
   logic                  own_valid;
   logic                  own_eop;
   logic                  own_error;
   logic [PKT_DATA_W-1:0] own_data;

   // Qualified by rst_n so the discard path stays quiet while reset is held.
   assign in_idle = (state == ST_IDLE) && rst_n;
   assign req     = {s1_valid & s1_sop, s0_valid & s0_sop};
   assign discard = in_idle ? {s1_valid & ~s1_sop, s0_valid & ~s0_sop} : 2'b00;

   peg_l2_rs_rr_arb u_arb (
      .rmii_ref_clk (rmii_ref_clk),
      .rst_n        (rst_n),
      .req          (req),
      .grant_en     (in_idle),
      .grant        (arb_grant)
   );

   assign own_valid = owner[1] ? s1_valid : s0_valid;
   assign own_eop   = owner[1] ? s1_eop   : s0_eop;
   assign own_error = owner[1] ? s1_error : s0_error;
   assign own_data  = owner[1] ? s1_data  : s0_data;
   assign ipg_load  = config_rs_mii_speed_100_n_10 ? IPG_LOAD_100 : IPG_LOAD_10;

   always_comb begin
      pkt_valid     = 1'b0;
      pkt_sop       = 1'b0;
      pkt_eop       = 1'b0;
      pkt_error     = 1'b0;
      pkt_data      = '0;
      s0_ready      = discard[0];
      s1_ready      = discard[1];
      stat_grant    = 2'b00;
      stat_pkt_done = 1'b0;
      stat_underrun = 1'b0;
      stat_sop_err  = |discard;
      case (state)
         ST_PRE: begin
            pkt_valid  = 1'b1;
            pkt_sop    = (pre_cnt == 3'd0);
            pkt_data   = (pre_cnt == PRE_LAST) ? PKT_DATA_W'(SFD_BYTE)
                                               : PKT_DATA_W'(PREAMBLE_BYTE);
            stat_grant = owner;
         end
         ST_DATA: begin
            pkt_valid             = own_valid;
            pkt_data              = own_data;
            pkt_eop               = own_eop;
            pkt_error             = own_error;
            {s1_ready, s0_ready}  = pkt_ready ? owner : 2'b00;
            stat_grant            = owner;
            stat_pkt_done         = own_valid & own_eop & pkt_ready;
            stat_underrun         = ~own_valid;
         end
         ST_DRAIN: begin
            {s1_ready, s0_ready} = owner;
            stat_grant           = owner;
         end
         default: ;
      endcase
   end

   always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         owner   <= 2'b00;
         pre_cnt <= 3'd0;
         ipg_cnt <= 9'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_grant != 2'b00) begin
                  owner   <= arb_grant;
                  pre_cnt <= 3'd0;
                  state   <= ST_PRE;
               end
            end
            ST_PRE: begin
               if (pkt_ready) begin
                  pre_cnt <= pre_cnt + 3'd1;
                  if (pre_cnt == PRE_LAST) state <= ST_DATA;
               end
            end
            ST_DATA: begin
               // A missing byte truncates the frame; the rest of it is drained.
               if (!own_valid) begin
                  if (own_eop) begin
                     ipg_cnt <= ipg_load;
                     state   <= ST_IPG;
                  end else begin
                     state   <= ST_DRAIN;
                  end
               end else if (pkt_ready && own_eop) begin
                  ipg_cnt <= ipg_load;
                  state   <= ST_IPG;
               end
            end
            ST_DRAIN: begin
               if (own_valid && own_eop) begin
                  ipg_cnt <= ipg_load;
                  state   <= ST_IPG;
               end
            end
            ST_IPG: begin
               if (ipg_cnt == 9'd0) begin
                  owner <= 2'b00;
                  state <= ST_IDLE;
               end else begin
                  ipg_cnt <= ipg_cnt - 9'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_peg_l2_rs_rmii_tx_sched.sv
// Directed bench for the RMII TX scheduler: behavioural sources, byte monitor
// on the serializer side, hand-computed expectations.
module tb_peg_l2_rs_rmii_tx_sched;

   logic       rmii_ref_clk = 1'b0;
   logic       rst_n;
   logic       cfg;
   logic       s0_valid, s0_sop, s0_eop, s0_error, s0_ready;
   logic [7:0] s0_data;
   logic       s1_valid, s1_sop, s1_eop, s1_error, s1_ready;
   logic [7:0] s1_data;
   logic       pkt_valid, pkt_sop, pkt_eop, pkt_error, pkt_ready;
   logic [7:0] pkt_data;
   logic [1:0] stat_grant;
   logic       stat_pkt_done, stat_underrun, stat_sop_err;

   always #10 rmii_ref_clk = ~rmii_ref_clk;

   peg_l2_rs_rmii_tx_sched #(.PKT_DATA_W(8), .NUM_PREAMBLE(7), .IPG_BYTES(12)) dut (
      .rmii_ref_clk                 (rmii_ref_clk),
      .rst_n                        (rst_n),
      .config_rs_mii_speed_100_n_10 (cfg),
      .s0_valid (s0_valid), .s0_sop (s0_sop), .s0_eop (s0_eop), .s0_error (s0_error),
      .s0_data  (s0_data),  .s0_ready (s0_ready),
      .s1_valid (s1_valid), .s1_sop (s1_sop), .s1_eop (s1_eop), .s1_error (s1_error),
      .s1_data  (s1_data),  .s1_ready (s1_ready),
      .pkt_valid (pkt_valid), .pkt_sop (pkt_sop), .pkt_eop (pkt_eop), .pkt_error (pkt_error),
      .pkt_data  (pkt_data),  .pkt_ready (pkt_ready),
      .stat_grant    (stat_grant),
      .stat_pkt_done (stat_pkt_done),
      .stat_underrun (stat_underrun),
      .stat_sop_err  (stat_sop_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] mem  [2][256];
   bit         sopf [2][256];
   bit         eopf [2][256];
   bit         errf [2][256];
   int         len  [2];
   int         idx  [2];
   int         hole_idx;
   bit         stall_en;
   int         cyc;
   logic       hole_pkt_valid;
   int         n_done, n_under, n_soperr;

   logic [7:0] o_data  [$];
   bit         o_sop   [$];
   bit         o_eop   [$];
   bit         o_err   [$];
   logic [1:0] o_grant [$];
   int         o_cyc   [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic drive();
      bit h;
      h         = (hole_idx >= 0) && (idx[0] == hole_idx);
      s0_valid  = (idx[0] < len[0]) && !h;
      s0_data   = mem[0][idx[0]];
      s0_sop    = sopf[0][idx[0]];
      s0_eop    = eopf[0][idx[0]];
      s0_error  = errf[0][idx[0]];
      s1_valid  = (idx[1] < len[1]);
      s1_data   = mem[1][idx[1]];
      s1_sop    = sopf[1][idx[1]];
      s1_eop    = eopf[1][idx[1]];
      s1_error  = errf[1][idx[1]];
      pkt_ready = !(stall_en && (cyc % 7 == 3));
   endtask

   task automatic step();
      drive();
      @(negedge rmii_ref_clk);
      if (pkt_valid && pkt_ready) begin
         o_data.push_back(pkt_data);
         o_sop.push_back(pkt_sop);
         o_eop.push_back(pkt_eop);
         o_err.push_back(pkt_error);
         o_grant.push_back(stat_grant);
         o_cyc.push_back(cyc);
      end
      if (stat_pkt_done) n_done++;
      if (stat_underrun) n_under++;
      if (stat_sop_err)  n_soperr++;
      if (hole_idx >= 0 && idx[0] == hole_idx && !s0_valid) begin
         hole_pkt_valid = pkt_valid;
         hole_idx       = -1;
      end
      if (s0_valid && s0_ready) idx[0]++;
      if (s1_valid && s1_ready) idx[1]++;
      @(posedge rmii_ref_clk);
      #1;
      cyc++;
   endtask

   task automatic clear_log();
      o_data.delete(); o_sop.delete(); o_eop.delete();
      o_err.delete();  o_grant.delete(); o_cyc.delete();
      n_done = 0; n_under = 0; n_soperr = 0;
   endtask

   task automatic reset_src();
      len[0] = 0; len[1] = 0; idx[0] = 0; idx[1] = 0; hole_idx = -1;
   endtask

   task automatic load_pkt(input int src, input int n, input logic [7:0] seed);
      for (int i = 0; i < n; i++) begin
         mem[src][len[src] + i]  = seed + 8'(i);
         sopf[src][len[src] + i] = (i == 0);
         eopf[src][len[src] + i] = (i == n - 1);
         errf[src][len[src] + i] = 1'b0;
      end
      len[src] += n;
   endtask

   task automatic wait_done(input string tag, input int budget, input int tail);
      int k;
      k = 0;
      while ((idx[0] < len[0] || idx[1] < len[1]) && k < budget) begin
         step();
         k++;
      end
      check(tag, 32'(k < budget), 32'd1);
      repeat (tail) step();
   endtask

   task automatic do_reset();
      reset_src();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      clear_log();
   endtask

   function automatic int find_sop(input int from);
      for (int i = from; i < o_sop.size(); i++)
         if (o_sop[i]) return i;
      return -1;
   endfunction

   // Two-source tie: s1 packet (4 bytes) first, then s0 (6 bytes) after the gap.
   task automatic tie_checks(input string pfx, input int exp_gap);
      int p1, p2;
      p1 = find_sop(0);
      p2 = (p1 >= 0) ? find_sop(p1 + 1) : -1;
      check({pfx, "_size"}, 32'(o_data.size()), 32'd26);
      check({pfx, "_first_pos"}, 32'(p1), 32'd0);
      check({pfx, "_second_pos"}, 32'(p2), 32'd12);
      if (p1 == 0 && p2 == 12) begin
         check({pfx, "_grant_first"}, 32'(o_grant[0]), 32'h2);
         check({pfx, "_s1_byte0"}, 32'(o_data[8]), 32'hA0);
         check({pfx, "_s1_eop"}, 32'(o_eop[11]), 32'd1);
         check({pfx, "_grant_second"}, 32'(o_grant[12]), 32'h1);
         check({pfx, "_s0_byte0"}, 32'(o_data[20]), 32'h30);
         check({pfx, "_gap"}, 32'(o_cyc[12] - o_cyc[11] - 1), 32'(exp_gap));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad, nsop, neop, nerr, pos;
      rst_n = 1'b0; cfg = 1'b1; stall_en = 1'b0; cyc = 0;
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 256; i++) begin
            mem[s][i] = 8'h00; sopf[s][i] = 0; eopf[s][i] = 0; errf[s][i] = 0;
         end
      reset_src();
      hole_pkt_valid = 1'b1;
      clear_log();
      drive();
      @(posedge rmii_ref_clk);
      #1;
      check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
      check("rst_grant", 32'(stat_grant), 32'd0);
      check("rst_s0_ready", 32'(s0_ready), 32'd0);
      check("rst_s1_ready", 32'(s1_ready), 32'd0);
      check("rst_pulses", 32'({stat_pkt_done, stat_underrun, stat_sop_err}), 32'd0);
      step();
      rst_n = 1'b1;
      clear_log();

      // Single 64-byte s0 packet at 100M with serializer stalls
      load_pkt(0, 64, 8'h10);
      errf[0][5] = 1'b1;
      stall_en = 1'b1;
      wait_done("t1_timeout", 600, 0);
      stall_en = 1'b0;
      repeat (60) step();
      check("t1_size", 32'(o_data.size()), 32'd72);
      for (int i = 0; i < 7; i++)
         if (i < o_data.size()) check("t1_preamble", 32'(o_data[i]), 32'h55);
      if (o_data.size() > 7) check("t1_sfd", 32'(o_data[7]), 32'hD5);
      bad = 0;
      for (int i = 0; i < 64; i++)
         if (i + 8 >= o_data.size() || o_data[i + 8] !== 8'h10 + 8'(i)) bad++;
      check("t1_data_bad", 32'(bad), 32'd0);
      nsop = 0; neop = 0; nerr = 0; bad = 0; pos = -1;
      for (int i = 0; i < o_data.size(); i++) begin
         if (o_sop[i]) nsop++;
         if (o_eop[i]) begin neop++; pos = i; end
         if (o_err[i]) nerr++;
         if (o_grant[i] !== 2'b01) bad++;
      end
      check("t1_sop_count", 32'(nsop), 32'd1);
      check("t1_sop_first", 32'(o_sop.size() > 0 ? o_sop[0] : 1'b0), 32'd1);
      check("t1_eop_count", 32'(neop), 32'd1);
      check("t1_eop_pos", 32'(pos), 32'd71);
      check("t1_err_count", 32'(nerr), 32'd1);
      check("t1_err_pos", 32'(o_err.size() > 13 ? o_err[13] : 1'b0), 32'd1);
      check("t1_grant_bad", 32'(bad), 32'd0);
      check("t1_done", 32'(n_done), 32'd1);
      check("t1_idle_grant", 32'(stat_grant), 32'd0);

      // Simultaneous SOP from reset: s1 first, 100M gap
      do_reset();
      load_pkt(1, 4, 8'hA0);
      load_pkt(0, 6, 8'h30);
      wait_done("t2_timeout", 400, 60);
      tie_checks("t2_100m", 49);
      check("t2_done", 32'(n_done), 32'd2);

      // Same tie at 10M; last grant was s0 so s1 wins again
      cfg = 1'b0;
      reset_src();
      clear_log();
      load_pkt(1, 4, 8'hA0);
      load_pkt(0, 6, 8'h30);
      wait_done("t2b_timeout", 1500, 500);
      tie_checks("t2_10m", 481);
      cfg = 1'b1;

      // Back-to-back packets on both sources alternate grants
      reset_src();
      clear_log();
      load_pkt(1, 3, 8'hB0);
      load_pkt(1, 3, 8'hB8);
      load_pkt(0, 3, 8'h40);
      load_pkt(0, 3, 8'h48);
      wait_done("t3_timeout", 600, 60);
      check("t3_size", 32'(o_data.size()), 32'd44);
      if (o_data.size() == 44) begin
         check("t3_grant0", 32'(o_grant[0]), 32'h2);
         check("t3_grant1", 32'(o_grant[11]), 32'h1);
         check("t3_grant2", 32'(o_grant[22]), 32'h2);
         check("t3_grant3", 32'(o_grant[33]), 32'h1);
         check("t3_pkt2_byte0", 32'(o_data[30]), 32'hB8);
      end

      // Underrun after data byte 10 of 20
      reset_src();
      clear_log();
      load_pkt(0, 20, 8'h60);
      hole_idx = 10;
      hole_pkt_valid = 1'b1;
      wait_done("t4_timeout", 300, 60);
      hole_idx = -1;
      check("t4_underrun", 32'(n_under), 32'd1);
      check("t4_hole_pkt_valid", 32'(hole_pkt_valid), 32'd0);
      check("t4_size", 32'(o_data.size()), 32'd18);
      if (o_data.size() == 18) check("t4_last_byte", 32'(o_data[17]), 32'h69);
      check("t4_done", 32'(n_done), 32'd0);
      check("t4_drained", 32'(idx[0]), 32'd20);

      // Non-SOP bytes in IDLE are discarded
      reset_src();
      clear_log();
      for (int i = 0; i < 3; i++) begin
         mem[0][i] = 8'hC0 + 8'(i); sopf[0][i] = 0; eopf[0][i] = 0; errf[0][i] = 0;
      end
      len[0] = 3;
      wait_done("t5_timeout", 20, 3);
      check("t5_sop_err", 32'(n_soperr), 32'd3);
      check("t5_out", 32'(o_data.size()), 32'd0);
      check("t5_consumed", 32'(idx[0]), 32'd3);

      // Async reset in the middle of the preamble
      reset_src();
      clear_log();
      load_pkt(0, 8, 8'h70);
      pos = 0;
      while (o_data.size() < 3 && pos < 30) begin step(); pos++; end
      check("t6_reached_pre", 32'(o_data.size()), 32'd3);
      s1_valid = 1'b1;
      s1_sop   = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("t6_rst_pkt_valid", 32'(pkt_valid), 32'd0);
      check("t6_rst_pkt_sop", 32'(pkt_sop), 32'd0);
      check("t6_rst_grant", 32'(stat_grant), 32'd0);
      check("t6_rst_ready", 32'({s1_ready, s0_ready}), 32'd0);
      check("t6_rst_sop_err", 32'(stat_sop_err), 32'd0);
      @(posedge rmii_ref_clk);
      #1;
      step();
      rst_n = 1'b1;
      clear_log();
      wait_done("t6_timeout", 100, 60);
      check("t6_size", 32'(o_data.size()), 32'd16);
      bad = 0;
      for (int i = 0; i < 7; i++)
         if (i >= o_data.size() || o_data[i] !== 8'h55) bad++;
      check("t6_preamble_bad", 32'(bad), 32'd0);
      if (o_data.size() == 16) begin
         check("t6_sfd", 32'(o_data[7]), 32'hD5);
         check("t6_sop", 32'(o_sop[0]), 32'd1);
         check("t6_byte0", 32'(o_data[8]), 32'h70);
      end
      check("t6_done", 32'(n_done), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
